cbus_arbiter: RTL

//  Round-robin arbiter merging NUM_MASTERS cbus request streams onto the single memory cbus.

---
 rtl/cbus_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter merging several cbus masters onto one memory cbus.
// Holds a grant from selection until the memory answers ready && last.

package cbus_pkg;
    localparam logic [7:0] MLEN1 = 8'd1;
    localparam logic [7:0] MLEN4 = 8'd4;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  cbus_req_t              req_i  [NUM_MASTERS],
    output cbus_resp_t             resp_o [NUM_MASTERS],
    output cbus_req_t              req_o,
    input  cbus_resp_t             resp_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic                   busy_o
);
    localparam int SEL_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] idx;
    logic             any_valid;

    // Scan starts just after the last served master, so it has lowest priority.
    always_comb begin
        pick      = '0;
        idx       = '0;
        any_valid = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = SEL_W'((int'(last_q) + i) % NUM_MASTERS);
            if (!any_valid && req_i[idx].valid) begin
                any_valid = 1'b1;
                pick      = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = BUSY;
                    sel_d   = pick;
                end
            end
            BUSY: begin
                if (resp_i.ready && resp_i.last) begin
                    state_d = IDLE;
                    last_d  = sel_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    // Responses reach only the granted master; memory sees nothing while idle.
    always_comb begin
        req_o   = '0;
        grant_o = '0;
        busy_o  = 1'b0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            resp_o[j] = '0;
        end
        if (state_q == BUSY) begin
            req_o          = req_i[sel_q];
            resp_o[sel_q]  = resp_i;
            grant_o[sel_q] = 1'b1;
            busy_o         = 1'b1;
        end
    end
endmodule
